// File: rtl/multi_sensor_alarm.sv
// Debounced multi-channel alarm: the lowest-index sensor held high for DEBOUNCE
// cycles raises a one-hot alarm, either for HOLD cycles or latched until ack.
module multi_sensor_alarm #(
  parameter int N_CH     = 3,
  parameter int DEBOUNCE = 7,
  parameter int HOLD     = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] sensor,
  input  logic            latch_mode,
  input  logic            ack,
  output logic [N_CH-1:0] alarm,
  output logic [2:0]      alarm_idx,
  output logic            busy,
  output logic [7:0]      trig_cnt,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_QUAL  = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  localparam logic [7:0]      QUAL_LAST = 8'(DEBOUNCE - 1);
  localparam logic [7:0]      HOLD_C    = 8'(HOLD);
  localparam logic [N_CH-1:0] ONE_HOT0  = N_CH'(1);

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      qual_cnt_q, qual_cnt_d;
  logic [7:0]      dur_cnt_q, dur_cnt_d;
  logic            mode_q, mode_d;
  logic [N_CH-1:0] alarm_q, alarm_d;
  logic            busy_q, busy_d;
  logic [7:0]      trig_cnt_q, trig_cnt_d;

  logic            cand_vld;
  logic [2:0]      cand_idx;

  // Scan from the top so the lowest asserted bit wins.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = 3'd0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (sensor[i]) begin
        cand_vld = 1'b1;
        cand_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    qual_cnt_d = qual_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    mode_d     = mode_q;
    alarm_d    = alarm_q;
    busy_d     = busy_q;
    trig_cnt_d = trig_cnt_q;

    if (!en) begin
      state_d    = S_IDLE;
      idx_d      = 3'd0;
      qual_cnt_d = 8'd0;
      dur_cnt_d  = 8'd0;
      mode_d     = 1'b0;
      alarm_d    = '0;
      busy_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cand_vld) begin
            state_d    = S_QUAL;
            idx_d      = cand_idx;
            qual_cnt_d = 8'd1;
            busy_d     = 1'b1;
          end else begin
            qual_cnt_d = 8'd0;
          end
        end
        S_QUAL: begin
          if (!cand_vld) begin
            state_d    = S_IDLE;
            idx_d      = 3'd0;
            qual_cnt_d = 8'd0;
            busy_d     = 1'b0;
          end else if (cand_idx != idx_q) begin
            idx_d      = cand_idx;
            qual_cnt_d = 8'd1;
          end else if (qual_cnt_q >= QUAL_LAST) begin
            state_d    = S_ALARM;
            qual_cnt_d = 8'd0;
            dur_cnt_d  = 8'd1;
            mode_d     = latch_mode;
            alarm_d    = ONE_HOT0 << idx_q;
            if (trig_cnt_q != 8'hFF) trig_cnt_d = trig_cnt_q + 8'd1;
          end else begin
            qual_cnt_d = qual_cnt_q + 8'd1;
          end
        end
        S_ALARM: begin
          // ack and timer expiry both land here, so they merge into one exit.
          if (ack || (!mode_q && dur_cnt_q >= HOLD_C)) begin
            state_d   = S_IDLE;
            idx_d     = 3'd0;
            dur_cnt_d = 8'd0;
            mode_d    = 1'b0;
            alarm_d   = '0;
            busy_d    = 1'b0;
          end else if (dur_cnt_q < HOLD_C) begin
            dur_cnt_d = dur_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d    = S_IDLE;
          idx_d      = 3'd0;
          qual_cnt_d = 8'd0;
          dur_cnt_d  = 8'd0;
          mode_d     = 1'b0;
          alarm_d    = '0;
          busy_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      qual_cnt_q <= 8'd0;
      dur_cnt_q  <= 8'd0;
      mode_q     <= 1'b0;
      alarm_q    <= '0;
      busy_q     <= 1'b0;
      trig_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      qual_cnt_q <= qual_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      mode_q     <= mode_d;
      alarm_q    <= alarm_d;
      busy_q     <= busy_d;
      trig_cnt_q <= trig_cnt_d;
    end
  end

  assign alarm     = alarm_q;
  assign alarm_idx = idx_q;
  assign busy      = busy_q;
  assign trig_cnt  = trig_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: doc/multi_sensor_alarm.md
MULTI_SENSOR_ALARM -- requirements
Module: multi_sensor_alarm

Interface
REQ-001 Parameter N_CH, default 3: number of sensor/alarm channels; legal range 1..8.
REQ-002 Parameter DEBOUNCE, default 7: consecutive sampled-high cycles required to qualify; legal range 2..255.
REQ-003 Parameter HOLD, default 31: timed-mode alarm length in cycles; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  block enable; en=0 forces IDLE on the next edge.
REQ-007 sensor  input  N_CH  raw synchronous sensor levels; bit 0 has the highest priority.
REQ-008 latch_mode  input  1  0 = timed alarm, 1 = alarm latched until ack.
REQ-009 ack  input  1  single-cycle alarm clear.
REQ-010 alarm  output  N_CH  one-hot registered alarm; all zero unless in ALARM.
REQ-011 alarm_idx  output  3  index of the active or qualifying channel; 0 in IDLE.
REQ-012 busy  output  1  high in QUAL or ALARM.
REQ-013 trig_cnt  output  8  count of alarms raised; saturates at 255.

Function
REQ-014 The block SHALL define the candidate as the lowest-index asserted bit of sensor in the current cycle.
REQ-015 The FSM SHALL have three states: IDLE, QUAL and ALARM; all outputs SHALL be registered.
REQ-016 IDLE: with a candidate present, the FSM SHALL go to QUAL, latch the candidate index and set qual_cnt=1; otherwise it SHALL stay in IDLE with qual_cnt=0.
REQ-017 QUAL, same candidate and qual_cnt<DEBOUNCE-1: qual_cnt SHALL increment.
REQ-018 QUAL, same candidate and qual_cnt=DEBOUNCE-1: the FSM SHALL enter ALARM at that edge.
  - alarm[idx] SHALL go to 1.
  - dur_cnt SHALL be set to 1.
  - latch_mode SHALL be captured.
  - trig_cnt SHALL increment (saturating).
  - Result: alarm rises on the edge that samples the DEBOUNCE-th consecutive high.
REQ-019 QUAL, different candidate: the FSM SHALL restart qualification on the new index with qual_cnt=1 and stay in QUAL.
REQ-020 QUAL, no candidate: the FSM SHALL return to IDLE and clear qual_cnt.
REQ-021 ALARM: sensor SHALL be ignored.
REQ-022 ALARM, timed mode: dur_cnt SHALL increment each cycle, and at dur_cnt=HOLD the FSM SHALL go to IDLE, giving alarm high for exactly HOLD cycles.
REQ-023 ALARM, latched mode: the alarm SHALL hold indefinitely, and dur_cnt SHALL saturate at HOLD.
REQ-024 ack=1 in ALARM SHALL go to IDLE at the next edge in either mode; ack SHALL be ignored in IDLE and QUAL.
REQ-025 ack and dur_cnt=HOLD in the same cycle SHALL produce a single return to IDLE with no double event.
REQ-026 en=0 in any state SHALL go to IDLE at the next edge.
  - alarm, qual_cnt and dur_cnt SHALL clear.
  - trig_cnt SHALL be preserved.
  - en=0 SHALL take precedence over qualification completion in the same cycle.
REQ-027 On return to IDLE, the FSM SHALL accept a new candidate on the following edge, never on the same edge.
REQ-028 latch_mode changes during ALARM SHALL have no effect until the next ALARM entry.
REQ-029 Counter widths SHALL be 8 bits, with no wrap for any legal parameter value.

Reset
REQ-030 rst=1 SHALL immediately and asynchronously force the following, independent of clk:
  - state = IDLE.
  - alarm = 0, alarm_idx = 0, busy = 0, trig_cnt = 0.
  - Internal counters cleared and captured mode cleared.
REQ-031 Deassertion of rst SHALL resume operation on the first rising edge after deassertion.
REQ-032 Reset asserted mid-QUAL or mid-ALARM SHALL discard all progress.

Verification
REQ-033 Defaults, en=1, latch_mode=0; sensor=3'b010 held 7 edges -> alarm=3'b010 after the 7th edge, high for exactly 31 cycles, alarm_idx=1, trig_cnt=1.
REQ-034 sensor[2] high 4 edges, then sensor[0] also high -> qualification restarts on idx 0; alarm=3'b001 after 7 further edges.
REQ-035 sensor[1] high 6 edges, low 1 edge, high 7 edges -> no alarm after the first burst; alarm=3'b010 after the 7th edge of the second burst.
REQ-036 latch_mode=1, sensor[0] qualifies -> alarm held for 100+ cycles; ack pulse -> alarm=0 next edge; sensor still high -> new qualification begins; trig_cnt increments only when it re-alarms.
REQ-037 Timed alarm active, ack asserted 5 cycles in -> alarm cleared; en=0 mid-QUAL -> busy=0 next edge; rst pulse mid-ALARM -> all outputs 0 immediately, without waiting for a clock edge.
REQ-038 256 alarms triggered -> trig_cnt reads 255.
